// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-beat signals of the
// shared single-port memory arbiter.
interface mem_port_arbiter_if #(
  parameter int N  = 64,
  parameter int AW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_rdata;
  logic          i_ready;
  logic          d_req;
  logic [1:0]    d_we;
  logic          d_dword;
  logic [N-1:0]  d_addr;
  logic [N-1:0]  d_wdata;
  logic [N-1:0]  d_rdata;
  logic          d_ready;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;
  logic          m_ack;
  logic          busy;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_dword,
    input  d_addr, d_wdata,
    input  m_rdata, m_ack,
    output i_rdata, i_ready,
    output d_rdata, d_ready,
    output m_req, m_we,
    output m_addr, m_wdata,
    output busy
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_dword,
    output d_addr, d_wdata,
    output m_rdata, m_ack,
    input  i_rdata, i_ready,
    input  d_rdata, d_ready,
    input  m_req, m_we,
    input  m_addr, m_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory
// between fetch and data ports; dwords go as two beats.
module mem_port_arbiter #(
  parameter int N  = 64,
  parameter int AW = 32
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, I_RD, D_LO, D_HI, DONE
  } state_e;

  state_e        state_q;
  logic          last_d_q;
  logic          wr_q;
  logic          dw_q;
  logic [31:0]   whi_q;
  logic          m_req_q;
  logic          m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [31:0]   m_wdata_q;
  logic [31:0]   i_rdata_q;
  logic [N-1:0]  d_rdata_q;
  logic          i_ready_q;
  logic          d_ready_q;

  logic          pick_d;
  logic          req_wr;
  logic          req_dw;
  logic [AW-1:0] d_base;
  logic          unused_bits;

  // last_d_q=1 hands a tie to the fetch port
  assign pick_d = bus.d_req &
                  (~bus.i_req | ~last_d_q);
  assign req_wr = bus.d_we[0];
  assign req_dw = req_wr ? bus.d_we[1]
                         : bus.d_dword;
  assign d_base = req_dw
    ? {bus.d_addr[AW-1:3], 3'b000}
    : {bus.d_addr[AW-1:2], 2'b00};

  assign unused_bits = ^{bus.d_addr[N-1:AW],
                         bus.d_addr[1:0],
                         bus.i_addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      wr_q      <= 1'b0;
      dw_q      <= 1'b0;
      whi_q     <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.i_req | bus.d_req) begin
            last_d_q <= pick_d;
            m_req_q  <= 1'b1;
            if (pick_d) begin
              wr_q      <= req_wr;
              dw_q      <= req_dw;
              whi_q     <= bus.d_wdata[63:32];
              m_we_q    <= req_wr;
              m_addr_q  <= d_base;
              m_wdata_q <= bus.d_wdata[31:0];
              state_q   <= D_LO;
            end else begin
              m_we_q   <= 1'b0;
              m_addr_q <= {bus.i_addr[AW-1:2], 2'b00};
              state_q  <= I_RD;
            end
          end
        end
        I_RD: begin
          if (bus.m_ack) begin
            i_rdata_q <= bus.m_rdata;
            m_req_q   <= 1'b0;
            i_ready_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        D_LO: begin
          if (bus.m_ack) begin
            if (!wr_q)
              d_rdata_q[31:0] <= bus.m_rdata;
            if (dw_q) begin
              // second beat keeps m_req high
              m_addr_q  <= m_addr_q + AW'(4);
              m_wdata_q <= whi_q;
              state_q   <= D_HI;
            end else begin
              if (!wr_q)
                d_rdata_q[N-1:32] <= '0;
              m_req_q   <= 1'b0;
              m_we_q    <= 1'b0;
              d_ready_q <= 1'b1;
              state_q   <= DONE;
            end
          end
        end
        D_HI: begin
          if (bus.m_ack) begin
            if (!wr_q)
              d_rdata_q[N-1:32] <= bus.m_rdata;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            d_ready_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.i_ready = i_ready_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.d_ready = d_ready_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases plus
// random traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int N  = 64;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.N(N), .AW(AW)) bus();

  mem_port_arbiter #(.N(N), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  beat_t       beats[$];
  logic [31:0] mem     [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];
  int          order[$];

  int n_tests = 0;
  int n_fail  = 0;
  int wlo, whi, wcnt, wait_n;
  logic        prev_req, prev_ack, prev_we;
  logic [63:0] prev_bus;

  int exp_port, last_port;
  bit arb_free, free_dly;

  logic [31:0] ti_addr;
  logic [1:0]  td_we;
  logic        td_dw;
  logic [31:0] td_addr;
  logic [63:0] td_wdata;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic set_mem(input logic [31:0] a,
                         input logic [31:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  task automatic complete(input int port);
    logic [31:0] base;
    logic        wr, dw;
    int          nb;
    chk("grant_order", 64'(port), 64'(exp_port));
    order.push_back(port);
    last_port = port;
    free_dly  = 1'b1;
    arb_free  = 1'b0;
    exp_port  = -1;
    if (port == 0) begin
      base = {ti_addr[31:2], 2'b00};
      chk("i_nbeats", 64'(beats.size()), 64'd1);
      if (beats.size() >= 1)
        chk("i_beat", {31'b0, beats[0].we, beats[0].addr},
            {31'b0, 1'b0, base});
      chk("i_rdata", 64'(bus.i_rdata), 64'(ref_rd(base)));
    end else begin
      wr   = td_we[0];
      dw   = wr ? td_we[1] : td_dw;
      base = dw ? {td_addr[31:3], 3'b000}
                : {td_addr[31:2], 2'b00};
      nb   = dw ? 2 : 1;
      chk("d_nbeats", 64'(beats.size()), 64'(nb));
      for (int k = 0; k < nb && k < beats.size(); k++) begin
        chk("d_beat", {31'b0, beats[k].we, beats[k].addr},
            {31'b0, wr, base + 32'(4 * k)});
        if (wr)
          chk("d_beat_wdata", 64'(beats[k].wdata),
              64'(td_wdata[32*k +: 32]));
      end
      if (wr) begin
        ref_mem[base] = td_wdata[31:0];
        if (dw) ref_mem[base + 32'd4] = td_wdata[63:32];
      end else begin
        chk("d_rdata", bus.d_rdata,
            dw ? {ref_rd(base + 32'd4), ref_rd(base)}
               : {32'h0, ref_rd(base)});
      end
    end
    beats.delete();
  endtask

  task automatic tick();
    beat_t b;
    // round-robin decision on the cycle now ending
    if (reset) begin
      if (free_dly) begin
        free_dly = 1'b0;
        arb_free = 1'b1;
      end else if (arb_free && (bus.i_req || bus.d_req)) begin
        exp_port = (bus.i_req && bus.d_req) ? 1 - last_port
                 : (bus.i_req ? 0 : 1);
        arb_free = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (bus.m_req) begin
      if (prev_req && !prev_ack) begin
        chk("stall_addr_wdata", {bus.m_addr, bus.m_wdata}, prev_bus);
        chk("stall_we", 64'(bus.m_we), 64'(prev_we));
      end
      if (wcnt >= wait_n) begin
        bus.m_ack   = 1'b1;
        bus.m_rdata = mem_rd(bus.m_addr);
        if (bus.m_we) mem[bus.m_addr] = bus.m_wdata;
        b.we = bus.m_we; b.addr = bus.m_addr; b.wdata = bus.m_wdata;
        beats.push_back(b);
        wcnt   = 0;
        wait_n = $urandom_range(whi, wlo);
      end else begin
        bus.m_ack   = 1'b0;
        bus.m_rdata = $urandom;
        wcnt++;
      end
    end else begin
      bus.m_ack   = 1'($urandom_range(1, 0));
      bus.m_rdata = $urandom;
    end
    prev_req = bus.m_req;
    prev_ack = bus.m_ack;
    prev_we  = bus.m_we;
    prev_bus = {bus.m_addr, bus.m_wdata};
    if (bus.i_ready || bus.d_ready)
      chk("ready_excl", 64'(bus.i_ready & bus.d_ready), 64'd0);
    if (bus.i_ready) complete(0);
    if (bus.d_ready) complete(1);
  endtask

  task automatic clr_model();
    beats.delete();
    wcnt     = 0;
    wait_n   = $urandom_range(whi, wlo);
    arb_free = 1'b0;
    free_dly = 1'b0;
    exp_port = -1;
    prev_req = 1'b0;
    prev_ack = 1'b0;
  endtask

  task automatic release_rst();
    reset     = 1'b1;
    last_port = 1;
    arb_free  = 1'b1;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    bus.i_req   = 1'b0;
    bus.d_req   = 1'b0;
    bus.m_ack   = 1'b0;
    clr_model();
    repeat (2) @(posedge clk);
    #1;
    release_rst();
  endtask

  task automatic set_d(input logic [1:0] we, input logic dw,
                       input logic [63:0] a, input logic [63:0] wd);
    td_we = we; td_dw = dw; td_addr = a[31:0]; td_wdata = wd;
    bus.d_we = we; bus.d_dword = dw;
    bus.d_addr = a; bus.d_wdata = wd;
    bus.d_req = 1'b1;
  endtask

  task automatic set_i(input logic [31:0] a);
    ti_addr    = a;
    bus.i_addr = a;
    bus.i_req  = 1'b1;
  endtask

  task automatic run_d(input logic [1:0] we, input logic dw,
                       input logic [63:0] a, input logic [63:0] wd,
                       output int lat);
    set_d(we, dw, a, wd);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.d_ready && lat < 200);
    if (!bus.d_ready) chk("d_ready_timeout", 64'd0, 64'd1);
    bus.d_req = 1'b0;
  endtask

  int lat;
  int n;

  initial begin
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_dword = 0;
    bus.d_addr = 0; bus.d_wdata = 0;
    bus.m_rdata = 0; bus.m_ack = 0;
    wlo = 0; whi = 0;
    reset = 1'b0;
    clr_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_req",   64'(bus.m_req),   64'd0);
    chk("rst_m_we",    64'(bus.m_we),    64'd0);
    chk("rst_i_ready", 64'(bus.i_ready), 64'd0);
    chk("rst_d_ready", 64'(bus.d_ready), 64'd0);
    chk("rst_busy",    64'(bus.busy),    64'd0);
    chk("rst_m_addr",  64'(bus.m_addr),  64'd0);
    chk("rst_m_wdata", 64'(bus.m_wdata), 64'd0);
    chk("rst_i_rdata", 64'(bus.i_rdata), 64'd0);
    chk("rst_d_rdata", bus.d_rdata,      64'd0);
    release_rst();

    // single zero-wait fetch
    set_mem(32'h40, 32'h20080005);
    set_i(32'h40);
    tick();
    chk("fetch_m_req",  64'(bus.m_req),  64'd1);
    chk("fetch_m_we",   64'(bus.m_we),   64'd0);
    chk("fetch_m_addr", 64'(bus.m_addr), 64'h40);
    chk("fetch_busy",   64'(bus.busy),   64'd1);
    tick();
    chk("fetch_ready", 64'(bus.i_ready), 64'd1);
    chk("fetch_rdata", 64'(bus.i_rdata), 64'h20080005);
    bus.i_req = 1'b0;
    tick();
    chk("fetch_ready_pulse", 64'(bus.i_ready), 64'd0);
    chk("fetch_busy_after",  64'(bus.busy),    64'd0);

    // dword write then dword read
    run_d(2'b11, 1'b0, 64'h100, 64'h1122334455667788, lat);
    chk("dw_wr_lat", 64'(lat), 64'd3);
    tick();
    run_d(2'b00, 1'b1, 64'h104, 64'h0, lat);
    chk("dw_rd_lat",  64'(lat), 64'd3);
    chk("dw_rd_data", bus.d_rdata, 64'h1122334455667788);
    tick();

    // word read zero-extends; d_we=10 reads too
    set_mem(32'h20, 32'hFFFFFFF0);
    run_d(2'b00, 1'b0, 64'h20, 64'h0, lat);
    chk("wd_rd_lat",  64'(lat), 64'd2);
    chk("wd_rd_data", bus.d_rdata, 64'h00000000FFFFFFF0);
    tick();
    run_d(2'b10, 1'b1, 64'hFFFF_0000_0000_0023, 64'h0, lat);
    chk("we10_rd_data", bus.d_rdata,
        {ref_rd(32'h24), 32'hFFFFFFF0});
    tick();
    run_d(2'b01, 1'b1, 64'h2C, 64'hDEAD_BEEF_0BAD_F00D, lat);
    chk("wd_wr_lat", 64'(lat), 64'd2);
    tick();

    // contention from reset release
    do_reset();
    order.delete();
    set_i(32'h80);
    set_d(2'b00, 1'b1, 64'h100, 64'h0);
    n = 0;
    while (order.size() < 4 && n < 60) begin
      tick();
      n++;
      if (order.size() == 4) begin
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    chk("contention_count", 64'(order.size()), 64'd4);
    for (int k = 0; k < order.size() && k < 4; k++)
      chk("contention_order", 64'(order[k]), 64'(k % 2));
    tick();

    // three wait states per beat
    wlo = 3; whi = 3; wait_n = 3; wcnt = 0;
    run_d(2'b00, 1'b1, 64'h200, 64'h0, lat);
    chk("wait_lat", 64'(lat), 64'd9);
    tick();

    // reset during the second beat of a dword write
    set_d(2'b11, 1'b1, 64'h300, 64'hA1A2A3A4_B1B2B3B4);
    n = 0;
    while (!(bus.m_req && bus.m_addr == 32'h304) && n < 30) begin
      tick();
      n++;
    end
    chk("rst_mid_reach_hi", 64'(bus.m_addr), 64'h304);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_m_req", 64'(bus.m_req), 64'd0);
    chk("rst_mid_busy",  64'(bus.busy),  64'd0);
    clr_model();
    order.delete();
    set_i(32'h44);
    @(posedge clk);
    #1;
    release_rst();
    tick();
    chk("rst_mid_no_dready", 64'(bus.d_ready), 64'd0);
    n = 0;
    while (order.size() < 2 && n < 60) begin
      tick();
      n++;
      if (bus.i_ready) bus.i_req = 1'b0;
      if (bus.d_ready) bus.d_req = 1'b0;
    end
    chk("rst_mid_count", 64'(order.size()), 64'd2);
    if (order.size() >= 1)
      chk("rst_mid_first_i", 64'(order[0]), 64'd0);
    tick();

    // random traffic
    wlo = 0; whi = 2;
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (bus.i_ready) begin
        if ($urandom_range(1, 0) == 1)
          set_i({24'h0, 8'($urandom_range(255, 0))});
        else
          bus.i_req = 1'b0;
      end else if (!bus.i_req && $urandom_range(2, 0) == 0) begin
        set_i({24'h0, 8'($urandom_range(255, 0))});
      end
      if (bus.d_ready) begin
        if ($urandom_range(1, 0) == 1)
          set_d(2'($urandom), 1'($urandom),
                {$urandom, 24'h0, 8'($urandom_range(255, 0))},
                {$urandom, $urandom});
        else
          bus.d_req = 1'b0;
      end else if (!bus.d_req && $urandom_range(2, 0) == 0) begin
        set_d(2'($urandom), 1'($urandom),
              {$urandom, 24'h0, 8'($urandom_range(255, 0))},
              {$urandom, $urandom});
      end
    end
    n = 0;
    while ((bus.i_req || bus.d_req) && n < 300) begin
      tick();
      n++;
      if (bus.i_ready) bus.i_req = 1'b0;
      if (bus.d_ready) bus.d_req = 1'b0;
    end
    chk("drain_done", {62'b0, bus.i_req, bus.d_req}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 32-bit single-port backing memory between the CPU instruction-fetch port and the CPU data port.
- Sequences 64-bit data accesses as two 32-bit beats.
- Returns a one-cycle ready pulse per completed request.
- Sits between the mips core and the memory array, inside the cache/memory subsystem; the core stalls on its request until the ready pulse arrives.

Parameters:
- N, 64, data-port width in bits; only N=64 is supported.
- AW, 32, memory address width in bits.

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction fetch request; held high until i_ready.
- i_addr  in  AW  fetch address; bits [1:0] are ignored.
- i_rdata  out  32  fetched word; valid while i_ready=1 and held until the next i_ready.
- i_ready  out  1  one-cycle completion pulse for the fetch port.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  2  write type: 00 read, 01 word write, 11 dword write, 10 treated as 00.
- d_dword  in  1  read size: 1 = 64-bit, 0 = 32-bit; ignored on writes.
- d_addr  in  N  data address; uses bits [AW-1:0]; bits [1:0] are ignored, and bit [2] is also ignored for dword accesses.
- d_wdata  in  N  write data.
- d_rdata  out  N  read data; held until the next d_ready.
- d_ready  out  1  one-cycle completion pulse for the data port.
- m_req  out  1  memory beat request; registered.
- m_we  out  1  memory beat write enable.
- m_addr  out  AW  memory beat address, word-aligned.
- m_wdata  out  32  memory beat write data.
- m_rdata  in  32  memory read data; valid when m_ack=1.
- m_ack  in  1  beat complete; may be high in the same cycle as m_req. Ignored while m_req=0.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous)
  - state goes to IDLE.
  - m_req, m_we, i_ready, d_ready and busy go to 0.
  - m_addr, m_wdata, i_rdata and d_rdata go to 0.
  - last_grant goes to D, so the first tie is won by I (boot fetch).
  - Reset mid-transaction abandons the beat: no ready pulse, and partial dword writes are not rolled back.
- FSM states: IDLE, I_RD, D_LO, D_HI, DONE.
- IDLE: samples i_req and d_req.
  - Only one request pending: grant that port.
  - Both pending: grant the port opposite to last_grant.
  - Grant updates last_grant and captures addr, wdata, we and size into internal registers; later input changes are ignored.
  - Next state is I_RD for an I grant, otherwise D_LO.
- I_RD
  - Drives m_req=1, m_we=0, m_addr={i_addr[AW-1:2],2'b00}.
  - On m_ack: i_rdata<=m_rdata, then go to DONE.
- D_LO
  - Drives m_req=1, m_addr={addr[AW-1:3],3'b000} for a dword access, otherwise {addr[AW-1:2],2'b00}.
  - m_we=1 for d_we 01 or 11; m_wdata=wdata[31:0].
  - On m_ack, a read latches d_rdata[31:0]<=m_rdata.
  - Next state on m_ack: D_HI if the access is dword (d_we=11, or a read with d_dword=1); otherwise DONE.
  - On a word read, d_rdata[63:32]<=0 (zero-extend; sign handling belongs to the core).
- D_HI
  - Drives m_addr = D_LO address + 4, m_wdata=wdata[63:32].
  - On m_ack, a read latches d_rdata[63:32]<=m_rdata; then go to DONE.
- m_req drop between beats: m_req is registered, so it drops to 0 for at least the cycle in which state advances past an acked beat. There is no back-to-back beat without a bubble in the following cycle, except D_LO to D_HI, where m_req stays 1 and only m_addr and m_wdata change.
- DONE: asserts the granted port's ready for exactly one cycle, then goes to IDLE. Requests are not sampled in DONE.
- Latency with a zero-wait memory (ack in the same cycle as m_req), measured from the req-sampled cycle:
  - word: ready at +2.
  - dword: ready at +3.
  - Minimum issue interval is 3 cycles for a word and 4 for a dword.
- Requester drops req mid-transaction: the transaction still completes and ready still pulses.
- A requester holding req high through its ready pulse starts a new transaction at the next IDLE sample, subject to round-robin against the other port.
- m_ack held high for several cycles: counts once per state; the ack in the m_req=0 bubble cycle is ignored.
- Memory stall: holds the current state and keeps every m_* output stable indefinitely.

Test Plan:
- Single fetch: i_req=1, i_addr=0x40, memory returns 0x20080005 with ack in the same cycle -> m_addr=0x40 one cycle after the req sample, i_ready one cycle later with i_rdata=0x20080005, busy low afterwards.
- Dword write then read: d_we=11, addr=0x100, wdata=0x1122334455667788 -> beats (0x100,0x55667788) then (0x104,0x11223344). A following dword read of 0x104 -> beats at 0x100/0x104 and d_rdata=0x1122334455667788.
- Word read zero-extension: memory[0x20]=0xFFFFFFF0, d_dword=0 -> d_rdata=0x00000000FFFFFFF0.
- Contention: i_req and d_req held high continuously from reset release -> grant order I,D,I,D. Each ready pulses exactly once per transaction and never both in the same cycle.
- Wait states: m_ack delayed 3 cycles per beat on a dword read -> m_* stable through the stall, d_ready 9 cycles after the req sample.
- Reset mid-D_HI: assert reset during the second beat -> m_req=0 immediately, no d_ready pulse, then a fresh i_req is granted first after release.
